// File: rtl/data_island_scheduler.sv
// HDMI data-island scheduler: places preamble/guard/packet periods into horizontal
// blanking and round-robin shares packet slots. Optional DIS_STATS_EN adds o_deferred.
module data_island_scheduler #(
    parameter int H_BLANK       = 160,
    parameter int NUM_REQ       = 4,
    parameter int CTRL_LEAD     = 4,
    parameter int VIDEO_RESERVE = 14,
    parameter int MAX_PACKETS   = 2
) (
    input  logic               i_pixel_clk,
    input  logic               i_reset_n,
    input  logic               i_disp_enable,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_period,
    output logic [4:0]         o_word,
    output logic               o_pkt_start,
    output logic               o_pkt_last,
    output logic               o_overrun
`ifdef DIS_STATS_EN
    ,
    output logic [15:0]        o_deferred
`endif
);

    // state         | meaning
    // S_IDLE        | waiting for DE to fall (also after abort / reset)
    // S_LEAD        | control lead-in, island decision at bc == CTRL_LEAD-1
    // S_PREAMBLE    | 8 preamble cycles
    // S_LEAD_GUARD  | 2 leading guard-band cycles
    // S_PACKET      | 32 data words of one packet, grant held
    // S_TRAIL_GUARD | 2 trailing guard-band cycles
    // S_DONE        | island finished or skipped for this line
    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_PREAMBLE, S_LEAD_GUARD, S_PACKET, S_TRAIL_GUARD, S_DONE
    } state_t;

    localparam int BCW = $clog2(H_BLANK + 1);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PCW = $clog2(MAX_PACKETS + 1);
    localparam bit ISLAND_FITS = (CTRL_LEAD + 10 + 32 + 2 + VIDEO_RESERVE) <= H_BLANK;

    state_t             state_q, state_d;
    logic [BCW-1:0]     bc_q, bc_d;
    logic               de_q;
    logic [2:0]         tmr_q, tmr_d;
    logic [4:0]         word_q, word_d;
    logic [PCW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         period_q, period_d;
    logic               pkt_start_q, pkt_start_d;
    logic               pkt_last_q, pkt_last_d;
    logic               overrun_q;

    logic               de_fall;
    logic               tmr_done;
    logic               more;
    logic               abort;
    logic               in_island;
    logic               found;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      idx;

    assign de_fall   = !i_disp_enable && de_q;
    assign tmr_done  = (tmr_q == 3'd0);
    assign in_island = (state_q == S_PREAMBLE) || (state_q == S_LEAD_GUARD) ||
                       (state_q == S_PACKET)   || (state_q == S_TRAIL_GUARD);
    // Back-to-back packet only if it and the trailing guard still leave the video reserve.
    assign more = (|i_req) && (pkt_cnt_q < PCW'(MAX_PACKETS)) &&
                  ((int'(bc_q) + 35 + VIDEO_RESERVE) <= H_BLANK);

    always_comb begin
        bc_d = bc_q;
        if (de_fall) begin
            bc_d = '0;
        end else if (bc_q < BCW'(H_BLANK)) begin
            bc_d = bc_q + BCW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (de_fall) state_d = S_LEAD;
            end
            S_LEAD: begin
                if (i_disp_enable) begin
                    state_d = S_IDLE;
                end else if (bc_q == BCW'(CTRL_LEAD - 1)) begin
                    state_d = (ISLAND_FITS && (|i_req)) ? S_PREAMBLE : S_DONE;
                end
            end
            S_PREAMBLE: begin
                if (tmr_done) state_d = S_LEAD_GUARD;
            end
            S_LEAD_GUARD: begin
                if (tmr_done) state_d = S_PACKET;
            end
            S_PACKET: begin
                if (word_q == 5'd31) state_d = more ? S_PACKET : S_TRAIL_GUARD;
            end
            S_TRAIL_GUARD: begin
                if (tmr_done) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_disp_enable && in_island) begin
            state_d = S_IDLE;
            abort   = 1'b1;
        end
    end

    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q) begin
            case (state_d)
                S_PREAMBLE:                  tmr_d = 3'd7;
                S_LEAD_GUARD, S_TRAIL_GUARD: tmr_d = 3'd1;
                default:                     tmr_d = 3'd0;
            endcase
        end else if (!tmr_done) begin
            tmr_d = tmr_q - 3'd1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        word_d      = '0;
        pkt_cnt_d   = pkt_cnt_q;
        gidx_d      = gidx_q;
        grant_d     = '0;
        found       = 1'b0;
        sel         = '0;
        idx         = '0;
        pkt_start_d = 1'b0;
        pkt_last_d  = 1'b0;

        // Pointer only moves when a granted packet completes, so an aborted one retries first.
        if (!abort && state_q == S_PACKET && word_q == 5'd31 && (|grant_q)) begin
            ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(ptr_d) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        if (state_d == S_PACKET) begin
            word_d = (state_q == S_PACKET) ? word_q + 5'd1 : 5'd0;
            grant_d = grant_q;
            if (word_d == 5'd0) begin
                pkt_cnt_d   = (state_q == S_PACKET) ? pkt_cnt_q + PCW'(1) : PCW'(1);
                grant_d     = found ? (NUM_REQ'(1) << sel) : '0;
                gidx_d      = sel;
                pkt_start_d = 1'b1;
            end
            pkt_last_d = (word_d == 5'd31);
        end

        case (state_d)
            S_PREAMBLE:                  period_d = 2'd1;
            S_LEAD_GUARD, S_TRAIL_GUARD: period_d = 2'd2;
            S_PACKET:                    period_d = 2'd3;
            default:                     period_d = 2'd0;
        endcase
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            bc_q        <= BCW'(H_BLANK);
            de_q        <= 1'b0;
            tmr_q       <= '0;
            word_q      <= '0;
            pkt_cnt_q   <= '0;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            period_q    <= '0;
            pkt_start_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bc_q        <= bc_d;
            de_q        <= i_disp_enable;
            tmr_q       <= tmr_d;
            word_q      <= word_d;
            pkt_cnt_q   <= pkt_cnt_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            period_q    <= period_d;
            pkt_start_q <= pkt_start_d;
            pkt_last_q  <= pkt_last_d;
            overrun_q   <= abort;
        end
    end

    assign o_grant     = grant_q;
    assign o_period    = period_q;
    assign o_word      = word_q;
    assign o_pkt_start = pkt_start_q;
    assign o_pkt_last  = pkt_last_q;
    assign o_overrun   = overrun_q;

`ifdef DIS_STATS_EN
    logic [15:0] deferred_q, deferred_d;
    logic        pend_q, pend_d;

    always_comb begin
        pend_d     = pend_q;
        deferred_d = deferred_q;
        if (de_fall) pend_d = 1'b0;
        if (state_d == S_DONE && state_q != S_DONE) pend_d = |i_req;
        if (((de_fall && pend_q) || abort) && deferred_q != 16'hFFFF) begin
            deferred_d = deferred_q + 16'd1;
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            deferred_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            deferred_q <= deferred_d;
            pend_q     <= pend_d;
        end
    end

    assign o_deferred = deferred_q;
`endif

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: table-driven lines, randomized request masks
// against a line-level schedule model, plus overrun, reset and budget corner cases.
module tb_data_island_scheduler;

    localparam int HB = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] o_grant;
    logic [1:0] o_period;
    logic [4:0] o_word;
    logic       o_pkt_start, o_pkt_last, o_overrun;

    logic [3:0] b_grant;
    logic [1:0] b_period;
    logic [4:0] b_word;
    logic       b_pkt_start, b_pkt_last, b_overrun;

`ifdef DIS_STATS_EN
    logic [15:0] o_deferred, b_deferred;
`endif

    data_island_scheduler dut (
        .i_pixel_clk   (clk),
        .i_reset_n     (rst_n),
        .i_disp_enable (de),
        .i_req         (req),
        .o_grant       (o_grant),
        .o_period      (o_period),
        .o_word        (o_word),
        .o_pkt_start   (o_pkt_start),
        .o_pkt_last    (o_pkt_last),
        .o_overrun     (o_overrun)
`ifdef DIS_STATS_EN
        ,
        .o_deferred    (o_deferred)
`endif
    );

    data_island_scheduler #(.H_BLANK(60)) dut_b (
        .i_pixel_clk   (clk),
        .i_reset_n     (rst_n),
        .i_disp_enable (de),
        .i_req         (req),
        .o_grant       (b_grant),
        .o_period      (b_period),
        .o_word        (b_word),
        .o_pkt_start   (b_pkt_start),
        .o_pkt_last    (b_pkt_last),
        .o_overrun     (b_overrun)
`ifdef DIS_STATS_EN
        ,
        .o_deferred    (b_deferred)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int p_m      = 0;

    typedef struct {
        logic [3:0] mask;
        int         n;
        int         g0;
        int         g1;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs at blank cycle bc for an island carrying n packets.
    function automatic void expect_at(input int bc, input int n, input int g0, input int g1,
                                      output logic [1:0] per, output logic [3:0] gr,
                                      output logic [4:0] w, output logic st, output logic lst);
        int k;
        per = 2'd0; gr = 4'd0; w = 5'd0; st = 1'b0; lst = 1'b0;
        if (n == 0) return;
        if (bc >= 4 && bc <= 11) per = 2'd1;
        else if (bc >= 12 && bc <= 13) per = 2'd2;
        else if (bc >= 14 && bc < 14 + 32 * n) begin
            k   = (bc - 14) / 32;
            per = 2'd3;
            w   = 5'((bc - 14) % 32);
            gr  = 4'(1 << ((k == 0) ? g0 : g1));
            st  = (w == 5'd0);
            lst = (w == 5'd31);
        end else if (bc >= 14 + 32 * n && bc < 16 + 32 * n) per = 2'd2;
    endfunction

    // Line-level schedule: how many packets fit and who gets them, round-robin from p_m.
    task automatic predict(input logic [3:0] mask, output int n, output int g0, output int g1);
        logic [3:0] pend;
        int start, k;
        pend = mask; n = 0; g0 = 0; g1 = 0; start = 14;
        if (pend != 4'd0 && (4 + 10 + 32 + 2 + 14) <= HB) begin
            while (1) begin
                k = p_m;
                while (((pend >> k) & 4'd1) == 4'd0) k = (k + 1) % 4;
                if (n == 0) g0 = k; else g1 = k;
                pend  = pend & ~(4'd1 << k);
                p_m   = (k + 1) % 4;
                n++;
                start += 32;
                if (pend == 4'd0 || n >= 2 || start + 48 > HB) break;
            end
        end
    endtask

    task automatic chk_cycle(input string tag, input int bc, input int n, input int g0, input int g1);
        logic [1:0] ep; logic [3:0] eg; logic [4:0] ew; logic es, el;
        expect_at(bc, n, g0, g1, ep, eg, ew, es, el);
        chk($sformatf("%s period bc%0d", tag, bc), 32'(o_period), 32'(ep));
        chk($sformatf("%s grant bc%0d", tag, bc), 32'(o_grant), 32'(eg));
        chk($sformatf("%s word bc%0d", tag, bc), 32'(o_word), 32'(ew));
        chk($sformatf("%s start bc%0d", tag, bc), 32'(o_pkt_start), 32'(es));
        chk($sformatf("%s last bc%0d", tag, bc), 32'(o_pkt_last), 32'(el));
        chk($sformatf("%s overrun bc%0d", tag, bc), 32'(o_overrun), 32'd0);
        chk($sformatf("%s budget_dut bc%0d", tag, bc),
            32'({b_period, b_grant, b_word, b_pkt_start, b_pkt_last, b_overrun}), 32'd0);
        if (o_pkt_start) req = req & ~o_grant;
    endtask

    task automatic run_line(input logic [3:0] mask, input int n, input int g0, input int g1,
                            input string tag);
        int starts;
        req = mask;
        repeat (3) begin
            @(negedge clk);
            chk($sformatf("%s de_high period", tag), 32'(o_period), 32'd0);
            chk($sformatf("%s de_high grant", tag), 32'(o_grant), 32'd0);
        end
        de = 1'b0;
        starts = 0;
        for (int bc = 0; bc < HB; bc++) begin
            @(negedge clk);
            if (o_pkt_start) starts++;
            chk_cycle(tag, bc, n, g0, g1);
        end
        de = 1'b1;
        chk($sformatf("%s packet_count", tag), 32'(starts), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, g0, g1, dn, d0, d1;
        logic [3:0] m;

        tbl[0] = '{4'b1111, 2, 0, 1};
        tbl[1] = '{4'b1111, 2, 2, 3};
        tbl[2] = '{4'b1111, 2, 0, 1};
        tbl[3] = '{4'b0010, 1, 1, 0};
        tbl[4] = '{4'b0000, 0, 0, 0};
        tbl[5] = '{4'b1001, 2, 3, 0};
        tbl[6] = '{4'b0101, 2, 2, 0};

        repeat (3) @(negedge clk);
        chk("reset period", 32'(o_period), 32'd0);
        chk("reset grant", 32'(o_grant), 32'd0);
        chk("reset word", 32'(o_word), 32'd0);
        chk("reset start", 32'(o_pkt_start), 32'd0);
        chk("reset last", 32'(o_pkt_last), 32'd0);
        chk("reset overrun", 32'(o_overrun), 32'd0);
`ifdef DIS_STATS_EN
        chk("reset deferred", 32'(o_deferred), 32'd0);
`endif
        rst_n = 1'b1;
        p_m = 0;

        for (int i = 0; i < 7; i++) begin
            predict(tbl[i].mask, dn, d0, d1);
            run_line(tbl[i].mask, tbl[i].n, tbl[i].g0, tbl[i].g1, $sformatf("tbl%0d", i));
        end

        // Overrun: DE rises mid-packet at bc 30.
        req = 4'b1111;
        repeat (3) @(negedge clk);
        de = 1'b0;
        for (int bc = 0; bc <= 30; bc++) begin
            @(negedge clk);
            chk_cycle("ovr", bc, 2, p_m, (p_m + 1) % 4);
        end
        de = 1'b1;
        @(negedge clk);
        chk("ovr period_after", 32'(o_period), 32'd0);
        chk("ovr grant_after", 32'(o_grant), 32'd0);
        chk("ovr pulse", 32'(o_overrun), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("ovr pulse_single", 32'(o_overrun), 32'd0);
            chk("ovr period_idle", 32'(o_period), 32'd0);
        end
        predict(4'b1111, n, g0, g1);
        run_line(4'b1111, n, g0, g1, "post_ovr");

        for (int r = 0; r < 12; r++) begin
            m = 4'($urandom_range(0, 15));
            predict(m, n, g0, g1);
            run_line(m, n, g0, g1, $sformatf("rnd%0d", r));
        end

        // Reset asserted inside a packet at bc 20.
        req = 4'b0001;
        repeat (3) @(negedge clk);
        de = 1'b0;
        for (int bc = 0; bc <= 20; bc++) begin
            @(negedge clk);
            chk_cycle("rst_mid", bc, 1, 0, 0);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async period", 32'(o_period), 32'd0);
        chk("rst_async grant", 32'(o_grant), 32'd0);
        chk("rst_async word", 32'(o_word), 32'd0);
        chk("rst_async start", 32'(o_pkt_start), 32'd0);
        chk("rst_async last", 32'(o_pkt_last), 32'd0);
        chk("rst_async overrun", 32'(o_overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("rst_no_island period", 32'(o_period), 32'd0);
            chk("rst_no_island grant", 32'(o_grant), 32'd0);
        end
        de = 1'b1;
        p_m = 0;
        run_line(4'b1111, 2, 0, 1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_island_scheduler.md
# data_island_scheduler

Schedules HDMI data-island periods into the horizontal blanking of each line and shares the island packet slots between several packet sources (audio clock regeneration, AVI InfoFrame, audio samples, …) with round-robin arbitration. Sits between `display_signal` and the `hdmi` output stage, on the pixel clock. It tells the TMDS encoder which period to emit (control / preamble / guard band / data) and tells the granted source which packet word to present.

## Interface
Parameters:
- `H_BLANK`, 160: total horizontal blanking pixels per line (front porch + sync + back porch).
- `NUM_REQ`, 4: number of packet requesters (2..8).
- `CTRL_LEAD`, 4: control cycles after DE falls before the island preamble.
- `VIDEO_RESERVE`, 14: cycles that must remain after the trailing guard band before DE rises.
- `MAX_PACKETS`, 2: packets per island (1..18).

Ports:
- `i_pixel_clk` in 1: pixel clock; all logic on rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_disp_enable` in 1: display enable from `display_signal`.
- `i_req` in NUM_REQ: per-source packet pending flag.
- `o_grant` out NUM_REQ: one-hot grant, held for the whole packet.
- `o_period` out 2: 0 CTRL, 1 PREAMBLE, 2 GUARD, 3 DATA.
- `o_word` out 5: packet word index 0..31 while DATA, else 0.
- `o_pkt_start` out 1: pulse on word 0.
- `o_pkt_last` out 1: pulse on word 31.
- `o_overrun` out 1: one-cycle pulse when an island is aborted by DE.

## Operation
- Blank counter `bc`: cleared to 0 on the first cycle `i_disp_enable` is low after being high. Increments each cycle and saturates at H_BLANK. Width $clog2(H_BLANK+1).
- States: IDLE, LEAD, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD, DONE.
- IDLE/DONE → LEAD on the DE falling edge.
- LEAD: at `bc == CTRL_LEAD-1`, go to PREAMBLE if `|i_req` and `CTRL_LEAD+10+32+2+VIDEO_RESERVE <= H_BLANK`. Otherwise go to DONE; no island on that line.
- PREAMBLE lasts 8 cycles, then LEAD_GUARD 2 cycles, then PACKET.
- PACKET lasts 32 cycles with `o_word` 0..31. On word 31, the next packet follows immediately only if all hold:
  - `|i_req`
  - packets issued < MAX_PACKETS
  - `bc+1+32+2+VIDEO_RESERVE <= H_BLANK`
  Otherwise go to TRAIL_GUARD (2 cycles), then DONE.
- Arbitration happens at PACKET entry. Round-robin starts from pointer `p` (0 after reset). After granting k, `p = (k+1) mod NUM_REQ`. The grant is fixed for 32 cycles.
- Handshake: a source keeps `i_req` high until it sees its `o_grant` with `o_pkt_start`. It must drop `i_req` by the following cycle unless it has another packet. `i_req` sampled on word 31 decides the next packet.
- DE rises while in PREAMBLE, LEAD_GUARD, PACKET or TRAIL_GUARD: go to IDLE at once, `o_period=0`, `o_grant=0`, pulse `o_overrun`. The pointer is not advanced for the aborted packet.
- DE high in IDLE/DONE: stay, CTRL.

## Timing
- All outputs registered. State/period change on the edge where `bc` takes the listed value.
- Defaults, two requesters pending:
  - PREAMBLE at bc 4–11
  - GUARD at 12–13
  - packet A at 14–45
  - packet B at 46–77
  - GUARD at 78–79
  - CTRL from 80
- Reset values: `o_grant=0`, `o_period=0`, `o_word=0`, `o_pkt_start=0`, `o_pkt_last=0`, `o_overrun=0`, state IDLE, `p=0`, `bc` saturated (H_BLANK).
- Reset asserted mid-island: outputs go to reset values asynchronously. The next island starts only after a fresh DE falling edge.

## Configuration
- `DIS_STATS_EN` defined: adds output `o_deferred` (16 bits, saturating at 0xFFFF). It increments by 1 on each DE falling edge where `|i_req` was still high at the previous island's end (DONE entry), and also on overrun. It clears on reset.
- `DIS_STATS_EN` undefined: the port and counter are absent. The rest of the behaviour is identical.

## Test plan
- Single source: `i_req=4'b0010` held until `o_pkt_start` → PREAMBLE bc 4–11, GUARD 12–13, `o_grant=0010` with `o_word` 0..31 on bc 14–45, GUARD 46–47, then CTRL.
- Fairness: `i_req=4'b1111` held continuously over 3 lines → grants 0,1 / 2,3 / 0,1; never more than 2 packets per line.
- No request: `i_req=0` for a whole line → `o_period` stays 0 and `o_grant` stays 0 for the full blanking.
- Budget: H_BLANK=60, defaults otherwise → `4+10+32+2+14 = 62 > 60`, so no island is ever started.
- Overrun: force DE high at bc 30 during a packet → the next cycle shows `o_period=0`, `o_grant=0`, and `o_overrun` pulses once.
- Reset: deassert `i_reset_n` at bc 20 → all outputs are 0 immediately. After release, no island until the next DE fall; the first grant goes to index 0.
